inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
Parametrised instruction fetch unit with a decoupling instruction queue between the AHB-Lite instruction port and decode.
- Issues one 32-bit fetch at a time and buffers up to DEPTH fetched instructions with their PCs.
- Predecodes JAL/JALR to steer the fetch PC.
- Accepts a single redirect input for branches, JALR targets and exceptions.
- Decode consumes instructions through a valid/ready handshake, replacing ad-hoc stall handling.

Parameters:
XLEN, 64, PC/address width (32 or 64)
DEPTH, 4, queue entries; power of two, >=2
RESET_PC, 0, first fetch address after reset

Ports:
CLK  in  1  clock, all state on posedge
reset  in  1  asynchronous, active-high reset
HADDR  out  XLEN  AHB address; valid while HTRANS=1
HTRANS  out  1  1 = request in address phase
HREADY  in  1  AHB ready; completes address or data phase
HRDATA  in  32  instruction data; valid in data phase when HREADY=1
redirect  in  1  flush queue and restart fetch
redirect_pc  in  XLEN  new fetch PC; bits [1:0] forced to 0
inst_valid  out  1  queue head valid
inst  out  32  queue head instruction
inst_pc  out  XLEN  queue head PC
inst_ready  in  1  decode accepts head when inst_valid=1

Behaviour:
Reset (asynchronous)
- state=S_RST, fetch_pc=RESET_PC, count=0, kill=0.
- Outputs: HTRANS=0, HADDR=RESET_PC, inst_valid=0, inst=0, inst_pc=0.

State S_RST
- Left on the first clock after reset drops, to S_ADDR.

State S_ADDR
- Drives HTRANS=1 and HADDR=fetch_pc only if count+inflight<DEPTH; otherwise HTRANS=0 and the state holds.
- When HTRANS=1 and HREADY=1: req_pc<=fetch_pc, go to S_DATA.

State S_DATA
- HTRANS=0. Wait for HREADY=1.
- On HREADY=1 with kill=0, push {HRDATA, req_pc}. Slot space is guaranteed by reservation at issue, so overflow is impossible.
- Next fetch_pc:
  - JAL: req_pc + sign-extended J-immediate.
  - JALR: go to S_HOLD.
  - Otherwise: req_pc+4, go to S_ADDR.
- On HREADY=1 with kill=1: discard HRDATA, clear kill, go to S_ADDR.

State S_HOLD
- HTRANS=0 until redirect.

Queue
- inst_valid = (count!=0). inst and inst_pc come from registered storage.
- Pop on inst_valid && inst_ready.
- Push and pop in the same cycle keep count unchanged, including when full.

Redirect (priority over every other event)
- count<=0 and fetch_pc<=redirect_pc.
- From S_HOLD or S_ADDR: go to S_ADDR. An address phase accepted in that same cycle is treated as killed (state S_DATA, kill=1).
- In S_DATA: stay in S_DATA with kill=1. If HREADY=1 in that same cycle, discard the data and go to S_ADDR.
- A pop in the redirect cycle is still accepted by decode; the entry is then flushed.

Arithmetic
- PC additions are modulo 2^XLEN, and the wrap from all-ones is silent.
- J-immediate is {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, sign-extended to XLEN.

Throughput
- Minimum 2 cycles per instruction with zero-wait-state memory.
- First inst_valid appears 3 cycles after reset deassertion.

Optional Feature:
Macro: INST_FETCH_PREDECODE_EN
- Defined: JAL/JALR predecode as described above.
- Undefined: fetch_pc is always req_pc+4 and S_HOLD is unreachable. Decode must redirect for JAL/JALR.

Decomposition:
- Package inst_fetch_pkg:
  - opcode constants OP_JAL=7'b1101111, OP_JALR=7'b1100111;
  - state enum S_RST/S_ADDR/S_DATA/S_HOLD;
  - jal_imm function (parametrised by XLEN).
- Sub-module inst_fetch_fifo: synchronous FIFO of width 32+XLEN and DEPTH entries, with push, pop, flush and count.
  - flush has priority over push.
  - Wrap-around uses log2(DEPTH)-bit pointers plus a count.

Test Plan:
1. Reset, zero-wait memory returning NOP (0x00000013), inst_ready=1 -> HADDR sequence 0,4,8,…; first inst_valid with inst_pc=0 in cycle 3.
2. inst_ready=0, DEPTH=4 -> exactly 4 fetches issued, then HTRANS=0; count=4; with inst_ready=1 fetching resumes within 1 cycle.
3. HRDATA=0x0100006F (JAL +16) at PC 0x20 with predecode enabled -> next HADDR=0x30; macro undefined -> next HADDR=0x24.
4. JALR fetched at 0x40 -> HTRANS=0 held; redirect_pc=0x1002 -> HADDR=0x1000 next cycle, queue empty.
5. Redirect to 0x200 during S_DATA with HREADY=0 for 3 cycles -> returning word not queued; next HADDR=0x200; no inst_valid for the stale PC.
6. Assert reset mid-S_DATA with the queue full -> HTRANS=0 and inst_valid=0 immediately (asynchronous); refetch from RESET_PC.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding, opcodes and
// the JAL immediate decoder.
package inst_fetch_pkg;

  localparam int MAX_XLEN = 64;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [1:0] {
    S_RST,
    S_ADDR,
    S_DATA,
    S_HOLD
  } state_t;

  // Sign-extended to the widest supported PC; callers keep the low XLEN bits,
  // which is identical to sign-extending directly to XLEN.
  function automatic logic [MAX_XLEN-1:0] jal_imm(input logic [31:0] ins);
    logic [20:0] imm;
    imm = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    return {{(MAX_XLEN-21){imm[20]}}, imm};
  endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Synchronous FIFO holding fetched {instruction, pc} pairs; head is read straight
// from registered storage, flush wins over push, push+pop when full is allowed.
module inst_fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// AHB-Lite instruction fetch with a decoupling queue to decode (valid/ready).
// Optional JAL/JALR predecode steering under INST_FETCH_PREDECODE_EN.
module inst_fetch_queue
  import inst_fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            reset,
  output logic [XLEN-1:0] HADDR,
  output logic            HTRANS,
  input  logic            HREADY,
  input  logic [31:0]     HRDATA,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t          state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic [XLEN-1:0] req_pc, req_pc_nxt;
  logic            kill, kill_nxt;

  logic            htrans;
  logic            push;
  logic            pop;
  logic            room;
  logic [CW-1:0]   count;
  logic [31+XLEN:0] head;

`ifdef INST_FETCH_PREDECODE_EN
  logic [MAX_XLEN-1:0] jimm_full;
  logic [XLEN-1:0]     jimm;
  assign jimm_full = jal_imm(HRDATA);
  assign jimm      = jimm_full[XLEN-1:0];
`endif

  // Only one fetch is ever outstanding, so nothing is in flight while an address
  // may issue and the slot reservation reduces to a free queue entry.
  assign room = (count < FULL);

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_pc_nxt   = req_pc;
    kill_nxt     = kill;
    htrans       = 1'b0;
    push         = 1'b0;

    case (state)
      S_RST: state_nxt = S_ADDR;
      S_ADDR: begin
        htrans = room;
        if (room && HREADY) begin
          req_pc_nxt = fetch_pc;
          state_nxt  = S_DATA;
        end
      end
      S_DATA: begin
        if (HREADY) begin
          state_nxt = S_ADDR;
          if (kill) begin
            kill_nxt = 1'b0;
          end else begin
            push         = 1'b1;
            fetch_pc_nxt = req_pc + XLEN'(4);
`ifdef INST_FETCH_PREDECODE_EN
            if (HRDATA[6:0] == OP_JAL) begin
              fetch_pc_nxt = req_pc + jimm;
            end else if (HRDATA[6:0] == OP_JALR) begin
              fetch_pc_nxt = fetch_pc;
              state_nxt    = S_HOLD;
            end
`endif
          end
        end
      end
      S_HOLD: state_nxt = S_HOLD;
      default: state_nxt = S_RST;
    endcase

    // Redirect overrides everything; an address accepted this cycle is marked dead.
    if (redirect) begin
      push         = 1'b0;
      fetch_pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
      case (state)
        S_DATA: begin
          if (HREADY) begin
            state_nxt = S_ADDR;
            kill_nxt  = 1'b0;
          end else begin
            state_nxt = S_DATA;
            kill_nxt  = 1'b1;
          end
        end
        S_ADDR: begin
          if (room && HREADY) begin
            state_nxt = S_DATA;
            kill_nxt  = 1'b1;
          end else begin
            state_nxt = S_ADDR;
          end
        end
        default: state_nxt = S_ADDR;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= S_RST;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      kill     <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_pc   <= req_pc_nxt;
      kill     <= kill_nxt;
    end
  end

  assign HTRANS     = htrans;
  assign HADDR      = fetch_pc;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign inst       = head[31+XLEN:XLEN];
  assign inst_pc    = head[XLEN-1:0];

  inst_fetch_fifo #(
    .WIDTH (32 + XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (reset),
    .push      (push),
    .push_data ({HRDATA, req_pc}),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a one-word-programmable AHB memory.
module tb_inst_fetch_queue;

  logic        CLK;
  logic        reset;
  logic [63:0] HADDR;
  logic        HTRANS;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;

  int checks = 0;
  int errors = 0;

  logic [63:0] dp_addr = '0;
  logic [63:0] sp_addr = '1;
  logic [31:0] sp_word = 32'h13;
  logic [63:0] addr_q[$];
  logic [63:0] pop_q[$];

  inst_fetch_queue #(
    .XLEN     (64),
    .DEPTH    (4),
    .RESET_PC (64'h0)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HREADY      (HREADY),
    .HRDATA      (HRDATA),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign HRDATA = (dp_addr == sp_addr) ? sp_word : 32'h0000_0013;

  always @(posedge CLK) begin
    if (HTRANS && HREADY) begin
      addr_q.push_back(HADDR);
      dp_addr <= HADDR;
    end
    if (inst_valid && inst_ready) pop_q.push_back(inst_pc);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset(input logic [63:0] a, input logic [31:0] w);
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0;
    HREADY = 1'b1; inst_ready = 1'b1; sp_addr = a; sp_word = w;
    repeat (2) @(posedge CLK);
    #1;
    addr_q.delete();
    pop_q.delete();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0;
    HREADY = 1'b1; inst_ready = 1'b1;
    tick();
    checks++; if (HTRANS !== 1'b0) begin errors++; $display("FAIL reset_htrans got %0h exp 0", HTRANS); end
    checks++; if (HADDR !== 64'h0) begin errors++; $display("FAIL reset_haddr got %0h exp 0", HADDR); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", inst_valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %0h exp 0", inst); end
    checks++; if (inst_pc !== 64'h0) begin errors++; $display("FAIL reset_pc got %0h exp 0", inst_pc); end
  endtask

  task automatic test_sequential();
    logic        eh, ev;
    logic [63:0] ea, ep;
    apply_reset('1, 32'h13);
    for (int k = 1; k <= 8; k++) begin
      tick();
      eh = k[0];
      ea = 64'((k - 1) * 2);
      ev = (k >= 3) && k[0];
      ep = 64'((k - 3) * 2);
      checks++; if (HTRANS !== eh) begin errors++; $display("FAIL seq_htrans c%0d got %0h exp %0h", k, HTRANS, eh); end
      if (eh) begin
        checks++; if (HADDR !== ea) begin errors++; $display("FAIL seq_haddr c%0d got %0h exp %0h", k, HADDR, ea); end
      end
      checks++; if (inst_valid !== ev) begin errors++; $display("FAIL seq_valid c%0d got %0h exp %0h", k, inst_valid, ev); end
      if (ev) begin
        checks++; if (inst_pc !== ep) begin errors++; $display("FAIL seq_pc c%0d got %0h exp %0h", k, inst_pc, ep); end
        checks++; if (inst !== 32'h13) begin errors++; $display("FAIL seq_inst c%0d got %0h exp 13", k, inst); end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset('1, 32'h13);
    inst_ready = 1'b0;
    repeat (14) tick();
    checks++; if (addr_q.size() != 4) begin errors++; $display("FAIL bp_fetches got %0d exp 4", addr_q.size()); end
    checks++; if (HTRANS !== 1'b0) begin errors++; $display("FAIL bp_htrans_full got %0h exp 0", HTRANS); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 64'h0) begin errors++; $display("FAIL bp_head got v%0h pc%0h exp v1 pc0", inst_valid, inst_pc); end
    inst_ready = 1'b1;
    tick();
    checks++; if (HTRANS !== 1'b1 || HADDR !== 64'h10) begin errors++; $display("FAIL bp_resume got t%0h a%0h exp t1 a10", HTRANS, HADDR); end
    checks++; if (inst_pc !== 64'h4) begin errors++; $display("FAIL bp_pop1 got %0h exp 4", inst_pc); end
    tick();
    checks++; if (inst_pc !== 64'h8) begin errors++; $display("FAIL bp_pop2 got %0h exp 8", inst_pc); end
  endtask

  task automatic test_jal();
    int          ia, ip;
    logic [63:0] exp_next;
`ifdef INST_FETCH_PREDECODE_EN
    exp_next = 64'h30;
`else
    exp_next = 64'h24;
`endif
    apply_reset(64'h20, 32'h0100_006F);
    repeat (30) tick();
    ia = -1; ip = -1;
    foreach (addr_q[i]) if (addr_q[i] == 64'h20 && ia < 0) ia = i;
    foreach (pop_q[i]) if (pop_q[i] == 64'h20 && ip < 0) ip = i;
    checks++;
    if (ia < 0 || ia + 1 >= addr_q.size()) begin
      errors++; $display("FAIL jal_fetch_next got none exp %0h", exp_next);
    end else if (addr_q[ia+1] !== exp_next) begin
      errors++; $display("FAIL jal_fetch_next got %0h exp %0h", addr_q[ia+1], exp_next);
    end
    checks++;
    if (ip < 0 || ip + 1 >= pop_q.size()) begin
      errors++; $display("FAIL jal_pop_next got none exp %0h", exp_next);
    end else if (pop_q[ip+1] !== exp_next) begin
      errors++; $display("FAIL jal_pop_next got %0h exp %0h", pop_q[ip+1], exp_next);
    end
  endtask

  task automatic test_jalr_redirect();
    bit found;
    int n, exp_more;
`ifdef INST_FETCH_PREDECODE_EN
    exp_more = 0;
`else
    exp_more = 3;
`endif
    apply_reset(64'h40, 32'h0000_80E7);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick();
      if (addr_q.size() > 0 && addr_q[$] == 64'h40) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL jalr_fetch got none exp 40"); end
    n = addr_q.size();
    repeat (6) tick();
    checks++; if (addr_q.size() - n != exp_more) begin errors++; $display("FAIL jalr_hold got %0d exp %0d", addr_q.size() - n, exp_more); end
    checks++; if (HTRANS !== 1'b0) begin errors++; $display("FAIL jalr_htrans got %0h exp 0", HTRANS); end
    redirect = 1'b1; redirect_pc = 64'h1002;
    tick();
    redirect = 1'b0;
    checks++; if (HTRANS !== 1'b1 || HADDR !== 64'h1000) begin errors++; $display("FAIL jalr_redir got t%0h a%0h exp t1 a1000", HTRANS, HADDR); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL jalr_empty got %0h exp 0", inst_valid); end
    repeat (2) tick();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 64'h1000) begin errors++; $display("FAIL jalr_new got v%0h pc%0h exp v1 pc1000", inst_valid, inst_pc); end
  endtask

  task automatic test_redirect_wait();
    apply_reset('1, 32'h13);
    repeat (2) tick();
    HREADY = 1'b0; redirect = 1'b1; redirect_pc = 64'h200;
    for (int k = 3; k <= 5; k++) begin
      tick();
      redirect = 1'b0;
      checks++; if (HTRANS !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rw_wait c%0d got t%0h v%0h exp t0 v0", k, HTRANS, inst_valid); end
    end
    HREADY = 1'b1;
    tick();
    checks++; if (HTRANS !== 1'b1 || HADDR !== 64'h200) begin errors++; $display("FAIL rw_refetch got t%0h a%0h exp t1 a200", HTRANS, HADDR); end
    checks++; if (inst_valid !== 1'b0 || pop_q.size() != 0) begin errors++; $display("FAIL rw_stale got v%0h pops%0d exp v0 pops0", inst_valid, pop_q.size()); end
    repeat (2) tick();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 64'h200) begin errors++; $display("FAIL rw_new got v%0h pc%0h exp v1 pc200", inst_valid, inst_pc); end
  endtask

  task automatic test_reset_mid();
    apply_reset('1, 32'h13);
    inst_ready = 1'b0;
    repeat (8) tick();
    HREADY = 1'b0;
    tick();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 64'h0) begin errors++; $display("FAIL rm_pre got v%0h pc%0h exp v1 pc0", inst_valid, inst_pc); end
    #3;
    reset = 1'b1;
    #1;
    checks++; if (HTRANS !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rm_async got t%0h v%0h exp t0 v0", HTRANS, inst_valid); end
    checks++; if (HADDR !== 64'h0) begin errors++; $display("FAIL rm_haddr got %0h exp 0", HADDR); end
    @(posedge CLK);
    #1;
    reset = 1'b0; HREADY = 1'b1; inst_ready = 1'b1;
    tick();
    checks++; if (HTRANS !== 1'b1 || HADDR !== 64'h0) begin errors++; $display("FAIL rm_refetch got t%0h a%0h exp t1 a0", HTRANS, HADDR); end
    repeat (2) tick();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 64'h0) begin errors++; $display("FAIL rm_first got v%0h pc%0h exp v1 pc0", inst_valid, inst_pc); end
  endtask

  task automatic test_wrap();
    apply_reset('1, 32'h13);
    tick();
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    redirect = 1'b0;
    checks++; if (HTRANS !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL wr_kill got t%0h v%0h exp t0 v0", HTRANS, inst_valid); end
    tick();
    checks++; if (HTRANS !== 1'b1 || HADDR !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wr_addr got t%0h a%0h exp t1 aFFFFFFFFFFFFFFFC", HTRANS, HADDR); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL wr_discard got %0h exp 0", inst_valid); end
    repeat (2) tick();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wr_head got v%0h pc%0h exp v1 pcFFFFFFFFFFFFFFFC", inst_valid, inst_pc); end
    checks++; if (HTRANS !== 1'b1 || HADDR !== 64'h0) begin errors++; $display("FAIL wr_wrap got t%0h a%0h exp t1 a0", HTRANS, HADDR); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_jal();
    test_jalr_redirect();
    test_redirect_wait();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
